pe_block_stream: RTL and testbench



---
 rtl/pe_pkg.sv | 44 ++++
 rtl/pe_mac_cell.sv | 42 ++++
 rtl/pe_block_stream.sv | 207 ++++++++++++++++++++
 tb/tb_pe_block_stream.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the streaming PE block.
// Latency: n/a (types, constants and a pure function).
// Backpressure: n/a.
// Contents: FSM state enum, default widths, and the shift-then-saturate helper.
package pe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_KLEN_W = 16;

  // Working width of the saturate helper; accumulators are sign-extended into it
  // so one function serves every ACC_W/DATA_W combination up to 64 bits.
  localparam int SAT_W = 64;

  // Arithmetic right shift, then clamp to the signed range of data_w bits.
  // The caller truncates the returned value to data_w bits.
  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] acc,
    input logic        [4:0]       shift,
    input int unsigned             data_w
  );
    logic signed [SAT_W-1:0] r;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    r  = acc >>> shift;
    hi = (SAT_W'(1) << (data_w - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    if (r > hi) begin
      saturate = hi;
    end else if (r < lo) begin
      saturate = lo;
    end else begin
      saturate = r;
    end
  endfunction

endpackage

// File: rtl/pe_mac_cell.sv
// Single signed MAC processing element: acc <= acc + data*weight when enabled.
// Latency: 1 cycle from enable to updated accumulator.
// Backpressure: none; iEn is the delayed beat-valid tag, bubbles simply hold acc.
// Ports: iClk/iRst clock and async reset, iClr clears acc (wins over iEn),
//        iEn accumulate strobe, iData/iWeight signed operands, oAcc accumulator.
module pe_mac_cell #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iClr,
  input  logic                     iEn,
  input  logic signed [DATA_W-1:0] iData,
  input  logic signed [DATA_W-1:0] iWeight,
  output logic signed [ACC_W-1:0]  oAcc
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  // Product formed at full ACC_W; overflow wraps at ACC_W by design.
  always_comb begin
    acc_d = acc_q;
    if (iClr) begin
      acc_d = '0;
    end else if (iEn) begin
      acc_d = acc_q + ACC_W'(iData) * ACC_W'(iWeight);
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign oAcc = acc_q;

endmodule

// File: rtl/pe_block_stream.sv
// BLOCK_NUM x ARRAY_NUM signed MAC array with job sequencer, row skew and shift-saturate output.
// Latency: oValid rises BLOCK_NUM+1 cycles after the cycle the last beat is accepted.
// Backpressure: oReady high only in ACCUM; results held in OUT until iReady.
// Ports: iClk/iRst; job control iStart/iKLen/iShift (+iReluEn when PE_BLOCK_STREAM_RELU_EN
//        is defined, forcing negative results to 0 per job); beat input iValid/oReady/iData/iWeight;
//        result output oValid/iReady/oResult; oBusy high outside IDLE.
module pe_block_stream
  import pe_pkg::*;
#(
  parameter int ARRAY_NUM = 3,
  parameter int BLOCK_NUM = 3,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int KLEN_W    = DEF_KLEN_W
) (
  input  logic                              iClk,
  input  logic                              iRst,
  input  logic                              iStart,
  input  logic [KLEN_W-1:0]                 iKLen,
  input  logic [4:0]                        iShift,
`ifdef PE_BLOCK_STREAM_RELU_EN
  input  logic                              iReluEn,
`endif
  input  logic                              iValid,
  output logic                              oReady,
  input  logic [DATA_W*ARRAY_NUM*BLOCK_NUM-1:0] iData,
  input  logic [DATA_W-1:0]                 iWeight,
  output logic                              oValid,
  input  logic                              iReady,
  output logic [DATA_W*ARRAY_NUM*BLOCK_NUM-1:0] oResult,
  output logic                              oBusy
);

  localparam int NPE     = ARRAY_NUM * BLOCK_NUM;
  localparam int ROW_W   = DATA_W * ARRAY_NUM;
  localparam int DLY_N   = (BLOCK_NUM > 1) ? BLOCK_NUM - 1 : 1;
  // Row b needs b data stages; stages are packed triangularly: row b stage s at b*(b-1)/2+s-1.
  localparam int DPIPE_N = (BLOCK_NUM > 1) ? BLOCK_NUM * (BLOCK_NUM - 1) / 2 : 1;
  localparam int FLUSH_W = $clog2(BLOCK_NUM + 1);

  state_e               state_q, state_d;
  logic [KLEN_W-1:0]    klen_q, klen_d;
  logic [KLEN_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [4:0]           shift_q, shift_d;
  logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [ROW_W-1:0]     dpipe_q [DPIPE_N];
  logic [ROW_W-1:0]     dpipe_d [DPIPE_N];
  logic [DATA_W-1:0]    wgt_dly_q [1:DLY_N];
  logic [DATA_W-1:0]    wgt_dly_d [1:DLY_N];
  logic                 vld_dly_q [1:DLY_N];
  logic                 vld_dly_d [1:DLY_N];
  logic [DATA_W*NPE-1:0] result_q, result_d;
  logic                 relu_q, relu_d;

  logic                 accept;
  logic                 start_ok;
  logic                 last_beat;
  logic                 flush_done;
  logic signed [DATA_W-1:0] sat;
  logic signed [ACC_W-1:0]  acc [NPE];

  assign start_ok   = (state_q == ST_IDLE) && iStart && (iKLen != '0);
  assign accept     = oReady && iValid;
  assign last_beat  = (beat_cnt_q == klen_q - KLEN_W'(1));
  assign flush_done = (flush_cnt_q == FLUSH_W'(BLOCK_NUM - 1));

  // FSM: state register
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_ok)            state_d = ST_ACCUM;
      ST_ACCUM: if (accept && last_beat) state_d = ST_FLUSH;
      ST_FLUSH: if (flush_done)          state_d = ST_OUT;
      ST_OUT:   if (iReady)              state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    oReady = (state_q == ST_ACCUM);
    oValid = (state_q == ST_OUT);
    oBusy  = (state_q != ST_IDLE);
  end

  // Job registers and counters
  always_comb begin
    klen_d      = klen_q;
    shift_d     = shift_q;
    beat_cnt_d  = beat_cnt_q;
`ifdef PE_BLOCK_STREAM_RELU_EN
    relu_d      = start_ok ? iReluEn : relu_q;
`else
    relu_d      = 1'b0;
`endif
    if (start_ok) begin
      klen_d     = iKLen;
      shift_d    = iShift;
      beat_cnt_d = '0;
    end
    if (accept) begin
      beat_cnt_d = beat_cnt_q + KLEN_W'(1);
    end
    flush_cnt_d = (state_q == ST_FLUSH) ? flush_cnt_q + FLUSH_W'(1) : '0;
  end

  // Skew: weight and valid tag shift one row per cycle; row b data rides b stages
  // so every row sees its own beat together with that beat's weight.
  always_comb begin
    for (int i = 0; i < DPIPE_N; i++) dpipe_d[i] = dpipe_q[i];
    for (int b = 1; b < BLOCK_NUM; b++) begin
      for (int s = 1; s <= b; s++) begin
        if (s == 1) dpipe_d[b*(b-1)/2] = iData[ROW_W*b +: ROW_W];
        else        dpipe_d[b*(b-1)/2 + s - 1] = dpipe_q[b*(b-1)/2 + s - 2];
      end
    end
    wgt_dly_d[1] = iWeight;
    vld_dly_d[1] = accept;
    for (int k = 2; k <= DLY_N; k++) begin
      wgt_dly_d[k] = wgt_dly_q[k-1];
      vld_dly_d[k] = vld_dly_q[k-1];
    end
  end

  // Output stage captures on the last FLUSH cycle, after the deepest row has accumulated.
  always_comb begin
    result_d = result_q;
    sat      = '0;
    if (state_q == ST_FLUSH && flush_done) begin
      for (int p = 0; p < NPE; p++) begin
        sat = DATA_W'(saturate(SAT_W'(acc[p]), shift_q, DATA_W));
        if (relu_q && sat[DATA_W-1]) sat = '0;
        result_d[DATA_W*p +: DATA_W] = sat;
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      klen_q      <= '0;
      shift_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      result_q    <= '0;
      relu_q      <= 1'b0;
      for (int i = 0; i < DPIPE_N; i++) dpipe_q[i] <= '0;
      for (int k = 1; k <= DLY_N; k++) begin
        wgt_dly_q[k] <= '0;
        vld_dly_q[k] <= 1'b0;
      end
    end else begin
      klen_q      <= klen_d;
      shift_q     <= shift_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      result_q    <= result_d;
      relu_q      <= relu_d;
      for (int i = 0; i < DPIPE_N; i++) dpipe_q[i] <= dpipe_d[i];
      for (int k = 1; k <= DLY_N; k++) begin
        wgt_dly_q[k] <= wgt_dly_d[k];
        vld_dly_q[k] <= vld_dly_d[k];
      end
    end
  end

  assign oResult = result_q;

  for (genvar gb = 0; gb < BLOCK_NUM; gb++) begin : g_row
    for (genvar ga = 0; ga < ARRAY_NUM; ga++) begin : g_col
      logic                     pe_en;
      logic signed [DATA_W-1:0] pe_dat;
      logic signed [DATA_W-1:0] pe_wgt;
      if (gb == 0) begin : g_head
        assign pe_en  = accept;
        assign pe_wgt = iWeight;
        assign pe_dat = iData[DATA_W*ga +: DATA_W];
      end else begin : g_skew
        localparam int IDX = gb*(gb-1)/2 + gb - 1;
        assign pe_en  = vld_dly_q[gb];
        assign pe_wgt = wgt_dly_q[gb];
        assign pe_dat = dpipe_q[IDX][DATA_W*ga +: DATA_W];
      end
      pe_mac_cell #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .iClk    (iClk),
        .iRst    (iRst),
        .iClr    (start_ok),
        .iEn     (pe_en),
        .iData   (pe_dat),
        .iWeight (pe_wgt),
        .oAcc    (acc[gb*ARRAY_NUM + ga])
      );
    end
  end

endmodule

// File: tb/tb_pe_block_stream.sv
// Randomised self-checking bench for pe_block_stream against a sum-of-products model.
// Latency: checks oValid rise at BLOCK_NUM+1 cycles after the last accepted beat.
// Backpressure: exercises iValid bubbles and iReady holds in OUT.
module tb_pe_block_stream;

  localparam int DW = 8;
  localparam int AW = 24;
  localparam int AN = 3;
  localparam int BN = 3;
  localparam int KW = 16;
  localparam int NP = AN * BN;

  logic              iClk = 1'b0;
  logic              iRst;
  logic              iStart;
  logic [KW-1:0]     iKLen;
  logic [4:0]        iShift;
  logic              iValid;
  logic              oReady;
  logic [DW*NP-1:0]  iData;
  logic [DW-1:0]     iWeight;
  logic              oValid;
  logic              iReady;
  logic [DW*NP-1:0]  oResult;
  logic              oBusy;

  int n_err = 0;
  int n_chk = 0;
  longint acc_m [NP];

  pe_block_stream dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iStart  (iStart),
    .iKLen   (iKLen),
    .iShift  (iShift),
    .iValid  (iValid),
    .oReady  (oReady),
    .iData   (iData),
    .iWeight (iWeight),
    .oValid  (oValid),
    .iReady  (iReady),
    .oResult (oResult),
    .oBusy   (oBusy)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected output of one PE: wrap the exact sum to AW bits, shift, clamp to DW bits.
  function automatic longint model_out(input longint acc, input int sh);
    longint a;
    longint r;
    a = acc & ((longint'(1) << AW) - 1);
    if (a >= (longint'(1) << (AW - 1))) a = a - (longint'(1) << AW);
    r = a >>> sh;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  // stall: 0 none, 1 iValid low every other cycle, 2 random. bp: cycles iReady held low in OUT.
  task automatic run_job(input int klen, input int sh, input int dval, input int wval,
                         input bit rnd, input int stall, input int bp);
    int n;
    int cyc;
    int lat;
    bit v;
    bit rdy;
    bit ready_ok;
    bit stable;
    int w;
    int d;
    logic [DW*NP-1:0] snap;
    for (int p = 0; p < NP; p++) acc_m[p] = 0;
    iReady = 1'b0;
    iKLen  = KW'(klen);
    iShift = 5'(sh);
    iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    chk("busy_after_start", oBusy, 1);
    n = 0;
    cyc = 0;
    ready_ok = 1'b1;
    while (n < klen && cyc < 2000) begin
      case (stall)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 1;
        default: v = $urandom_range(0, 1) == 1;
      endcase
      rdy = oReady;
      if (rdy !== 1'b1) ready_ok = 1'b0;
      w = rnd ? int'($urandom_range(0, 255)) - 128 : wval;
      iWeight = w[DW-1:0];
      for (int p = 0; p < NP; p++) begin
        d = rnd ? int'($urandom_range(0, 255)) - 128 : dval;
        iData[p*DW +: DW] = d[DW-1:0];
        if (v && rdy) acc_m[p] += longint'(d) * longint'(w);
      end
      iValid = v;
      @(posedge iClk); #1;
      if (v && rdy) n++;
      cyc++;
    end
    iValid = 1'b0;
    chk("ready_in_accum", ready_ok, 1);
    chk("beats_accepted", n, klen);
    chk("ready_after_last", oReady, 0);
    lat = 1;
    while (oValid !== 1'b1 && lat < 50) begin
      @(posedge iClk); #1;
      lat++;
    end
    chk("out_latency", lat, BN + 1);
    for (int p = 0; p < NP; p++)
      chk($sformatf("result%0d", p), $signed(oResult[p*DW +: DW]), model_out(acc_m[p], sh));
    snap = oResult;
    stable = 1'b1;
    for (int i = 0; i < bp; i++) begin
      if (i == 2) begin
        iKLen  = 16'd7;
        iStart = 1'b1;
      end
      @(posedge iClk); #1;
      iStart = 1'b0;
      if (oValid !== 1'b1 || oBusy !== 1'b1 || oResult !== snap) stable = 1'b0;
    end
    if (bp > 0) chk("out_hold_stable", stable, 1);
    iReady = 1'b1;
    @(posedge iClk); #1;
    iReady = 1'b0;
    chk("idle_after_ready", oBusy, 0);
    chk("valid_drop", oValid, 0);
    chk("result_held", oResult == snap, 1);
  endtask

  initial begin
    iRst = 1'b0; iStart = 1'b0; iValid = 1'b0; iReady = 1'b0;
    iKLen = '0; iShift = '0; iData = '0; iWeight = '0;
    #2 iRst = 1'b1;
    #1;
    chk("rst_ready", oReady, 0);
    chk("rst_valid", oValid, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_result", oResult == '0, 1);
    repeat (2) @(posedge iClk);
    #1 iRst = 1'b0;
    @(posedge iClk); #1;

    run_job(4, 0, 2, 3, 1'b0, 0, 0);        // defaults: 24s
    run_job(16, 0, 127, 127, 1'b0, 0, 0);   // positive saturation
    run_job(16, 0, -128, 127, 1'b0, 0, 0);  // negative saturation
    run_job(10, 3, 10, 10, 1'b0, 0, 0);     // 1000 >>> 3
    run_job(10, 3, -10, 10, 1'b0, 0, 0);    // -1000 >>> 3
    run_job(4, 0, 2, 3, 1'b0, 1, 0);        // bubbles every other cycle
    run_job(4, 0, 2, 3, 1'b0, 0, 5);        // iReady held low 5 cycles

    // Abort mid-ACCUM, then a clean job must show no residue.
    iKLen = 16'd4; iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    iData = {NP{8'sd5}}; iWeight = 8'sd5; iValid = 1'b1;
    repeat (2) @(posedge iClk);
    #1 iValid = 1'b0;
    iRst = 1'b1;
    #2;
    chk("abort_ready", oReady, 0);
    chk("abort_busy", oBusy, 0);
    chk("abort_result", oResult == '0, 1);
    @(posedge iClk); #1;
    chk("abort_valid", oValid, 0);
    iRst = 1'b0;
    @(posedge iClk); #1;
    run_job(4, 0, 2, 3, 1'b0, 0, 0);

    // Zero-length start is ignored.
    iKLen = '0; iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    chk("klen0_busy", oBusy, 0);
    @(posedge iClk); #1;
    chk("klen0_ready", oReady, 0);

    // Random jobs, including length-1 and random bubbles/backpressure.
    run_job(1, 0, 0, 0, 1'b1, 2, 1);
    for (int j = 0; j < 8; j++)
      run_job(int'($urandom_range(1, 12)), int'($urandom_range(0, 12)), 0, 0, 1'b1, 2,
              int'($urandom_range(0, 3)));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
